led_matrix_scanner: RTL

- Consumer end of the 16x16 red/green frame interface: takes the full redled/greenled frames from the display composer and drives the physical LED matrix one row at a time.
- Double-buffers each frame so the composer may change its frames at any time without tearing.
- Sits between the display composer and the board GPIO (row drivers and column sinks).

---
 rtl/led_pkg.sv | 15 +
 rtl/led_matrix_scanner_row_timer.sv | 26 ++
 rtl/led_matrix_scanner.sv | 128 ++++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared types for the LED matrix scanner: frame storage layout and scan FSM states.
package led_pkg;

  localparam int NUM_ROWS = 16;

  typedef logic [NUM_ROWS-1:0][15:0] frame_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SCAN,
    BLANK
  } scan_state_t;

endpackage

// File: rtl/led_matrix_scanner_row_timer.sv
// Row dwell timer: 16-bit counter that loads zero on clear and raises tc when it reaches term.
module row_timer (
  input  logic        Clock,
  input  logic        RST,
  input  logic        clear,
  input  logic        en,
  input  logic [15:0] term,
  output logic        tc
);

  logic [15:0] count;

  // Holds at the terminal value so tc cannot be overrun if the owner is late to clear it.
  always_ff @(posedge Clock) begin
    if (RST) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + 16'd1;
    end
  end

  assign tc = (count == term);

endmodule

// File: rtl/led_matrix_scanner.sv
// Double-buffered 16x16 red/green LED matrix row scanner.
// Define LED_GHOST_BLANK_EN to insert BLANK_CYCLES all-off cycles after every lit row.
module led_matrix_scanner
  import led_pkg::*;
#(
  parameter int DWELL_CYCLES = 3125,
  parameter int BLANK_CYCLES = 64
) (
  input  logic        Clock,
  input  logic        RST,
  input  logic        enable,
  input  frame_t      red_frame,
  input  frame_t      green_frame,
  output logic [15:0] row_sel_n,
  output logic [15:0] red_col,
  output logic [15:0] green_col,
  output logic        frame_tick
);

  scan_state_t state;
  logic [3:0]  row;
  logic [3:0]  next_row;
  frame_t      shadow_red;
  frame_t      shadow_green;
  logic        row_done;
  logic        timer_clear;
  logic        timer_en;
  logic [15:0] timer_term;

  assign next_row    = row + 4'd1;
  assign timer_en    = (state == SCAN) || (state == BLANK);
  assign timer_clear = !timer_en || row_done;
  assign timer_term  = (state == BLANK) ? 16'(BLANK_CYCLES - 1) : 16'(DWELL_CYCLES - 1);

  row_timer u_row_timer (
    .Clock (Clock),
    .RST   (RST),
    .clear (timer_clear),
    .en    (timer_en),
    .term  (timer_term),
    .tc    (row_done)
  );

  // Row 0 is driven straight from the inputs at LOAD because the shadow copy lands on the same edge.
  always_ff @(posedge Clock) begin
    if (RST) begin
      state        <= IDLE;
      row          <= '0;
      shadow_red   <= '0;
      shadow_green <= '0;
      row_sel_n    <= 16'hFFFF;
      red_col      <= '0;
      green_col    <= '0;
      frame_tick   <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      case (state)
        IDLE: begin
          row_sel_n <= 16'hFFFF;
          red_col   <= '0;
          green_col <= '0;
          if (enable) state <= LOAD;
        end
        LOAD: begin
          shadow_red   <= red_frame;
          shadow_green <= green_frame;
          frame_tick   <= 1'b1;
          row          <= '0;
          state        <= SCAN;
          row_sel_n    <= ~16'h0001;
          red_col      <= red_frame[0];
          green_col    <= green_frame[0];
        end
        SCAN: begin
          if (row_done) begin
            if (!enable) begin
              state     <= IDLE;
              row_sel_n <= 16'hFFFF;
              red_col   <= '0;
              green_col <= '0;
`ifdef LED_GHOST_BLANK_EN
            end else begin
              state     <= BLANK;
              row_sel_n <= 16'hFFFF;
              red_col   <= '0;
              green_col <= '0;
            end
`else
            end else if (row != 4'(NUM_ROWS - 1)) begin
              row       <= next_row;
              row_sel_n <= ~(16'h0001 << next_row);
              red_col   <= shadow_red[next_row];
              green_col <= shadow_green[next_row];
            end else begin
              state     <= LOAD;
              row_sel_n <= 16'hFFFF;
              red_col   <= '0;
              green_col <= '0;
            end
`endif
          end
        end
`ifdef LED_GHOST_BLANK_EN
        BLANK: begin
          if (row_done) begin
            if (row != 4'(NUM_ROWS - 1)) begin
              state     <= SCAN;
              row       <= next_row;
              row_sel_n <= ~(16'h0001 << next_row);
              red_col   <= shadow_red[next_row];
              green_col <= shadow_green[next_row];
            end else begin
              state <= LOAD;
            end
          end
        end
`endif
        default: begin
          state     <= IDLE;
          row_sel_n <= 16'hFFFF;
          red_col   <= '0;
          green_col <= '0;
        end
      endcase
    end
  end

endmodule
